// File: rtl/calc_pkg.sv
// calc_pkg: shared state encoding and mailbox constants for the calculator host sequencer.
package calc_pkg;
   typedef enum logic [2:0] {IDLE, WR_A, WR_B, WR_OP, WAIT, READ, CLR_OP, RESP} calcState_t;
   localparam logic [31:0] DEF_ADDR_OP  = 32'd0;
   localparam logic [31:0] DEF_ADDR_A   = 32'd16;
   localparam logic [31:0] DEF_ADDR_B   = 32'd20;
   localparam logic [31:0] DEF_ADDR_RES = 32'd24;
   localparam logic [31:0] OP_NONE      = 32'd0;
   function automatic int ctrWidth(input int latency);
      return (latency < 1) ? 1 : $clog2(latency + 1);
   endfunction
endpackage

// File: rtl/calc_wait_timer.sv
// calc_wait_timer: loadable down-counter; done is high while the count sits at 1.
module calc_wait_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] loadVal,
   output logic         done
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (load) cnt <= loadVal;
      else if (cnt != '0) cnt <= cnt - W'(1);
   assign done = cnt == W'(1);
endmodule

// File: rtl/calc_host_sequencer.sv
// calc_host_sequencer: writes operands/opcode into the calculator mailbox, waits, reads the result back.
module calc_host_sequencer
   import calc_pkg::*;
#(
   parameter logic [31:0] ADDR_OP   = DEF_ADDR_OP,
   parameter logic [31:0] ADDR_A    = DEF_ADDR_A,
   parameter logic [31:0] ADDR_B    = DEF_ADDR_B,
   parameter logic [31:0] ADDR_RES  = DEF_ADDR_RES,
   parameter int          LATENCY   = 64,
   parameter logic        WE_ACTIVE = 1'b0,
   parameter int          CLEAR_OP  = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [31:0] req_op,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic        resp_err,
   output logic        busy,
   output logic [31:0] EntradaCalcu,
   output logic [31:0] addressCalcu,
   output logic        writeEnableCalcu,
   input  logic [31:0] resultadoCalcu
);
   localparam int CW = ctrWidth(LATENCY);
   calcState_t state, stateNext;
   logic [31:0] regB, regOp, addrNext, dataNext;
   logic        wrNext, waitDone;
   calc_wait_timer #(.W(CW)) waitTimer (
      .clk(CLK), .rst(RST), .load(state == WR_OP), .loadVal(CW'(LATENCY)), .done(waitDone)
   );
   always_ff @(posedge CLK or posedge RST)
      if (RST) state <= IDLE;
      else state <= stateNext;
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (req_valid) stateNext = (req_op == OP_NONE) ? RESP : WR_A;
         WR_A:    stateNext = WR_B;
         WR_B:    stateNext = WR_OP;
         WR_OP:   stateNext = (LATENCY == 0) ? READ : WAIT;
         WAIT:    stateNext = waitDone ? READ : WAIT;
         READ:    stateNext = (CLEAR_OP != 0) ? CLR_OP : RESP;
         CLR_OP:  stateNext = RESP;
         RESP:    if (resp_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end
   // Bus values are computed for the upcoming state so the registered outputs line up with it.
   always_comb begin
      addrNext = 32'd0;
      dataNext = 32'd0;
      wrNext   = 1'b0;
      case (stateNext)
         WR_A:        {addrNext, dataNext, wrNext} = {ADDR_A, req_a, 1'b1};
         WR_B:        {addrNext, dataNext, wrNext} = {ADDR_B, regB, 1'b1};
         WR_OP:       {addrNext, dataNext, wrNext} = {ADDR_OP, regOp, 1'b1};
         WAIT, READ:  addrNext = ADDR_RES;
         CLR_OP:      {addrNext, wrNext} = {ADDR_OP, 1'b1};
         default:     wrNext = 1'b0;
      endcase
   end
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         EntradaCalcu     <= 32'd0;
         addressCalcu     <= 32'd0;
         writeEnableCalcu <= ~WE_ACTIVE;
      end else begin
         EntradaCalcu     <= dataNext;
         addressCalcu     <= addrNext;
         writeEnableCalcu <= wrNext ? WE_ACTIVE : ~WE_ACTIVE;
      end
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         regB      <= 32'd0;
         regOp     <= 32'd0;
         resp_data <= 32'd0;
         resp_err  <= 1'b0;
      end else if (state == IDLE && req_valid) begin
         regB      <= req_b;
         regOp     <= req_op;
         resp_data <= 32'd0;
         resp_err  <= req_op == OP_NONE;
      end else if (state == READ) begin
         resp_data <= resultadoCalcu;
      end else if (state == RESP && resp_ready) begin
         resp_err  <= 1'b0;
      end
   assign req_ready  = state == IDLE;
   assign busy       = state != IDLE;
   assign resp_valid = state == RESP;
endmodule

// File: doc/calc_host_sequencer.md
Name: calc_host_sequencer

Overview:
- Host-side master for the SingleCycleuProcessor calculator mailbox interface (EntradaCalcu / addressCalcu / writeEnableCalcu / resultadoCalcu).
- Accepts one operation request (operand A, operand B, opcode) on a valid/ready handshake.
- Writes the request into the processor's data-memory mailbox, waits a fixed compute window, then reads back the result.
- Returns the result on a valid/ready response channel and clears the opcode mailbox. Sits between the user front end (keypad/UART decoder) and the processor.

Parameters:
- ADDR_OP, 32'd0, mailbox address of the opcode word (0 = no operation pending)
- ADDR_A, 32'd16, mailbox address of operand A
- ADDR_B, 32'd20, mailbox address of operand B
- ADDR_RES, 32'd24, mailbox address read back as the result
- LATENCY, 64, cycles to wait after the opcode write before reading the result (0 allowed)
- WE_ACTIVE, 1'b0, level of writeEnableCalcu that commits a write (processor port is active-low)
- CLEAR_OP, 1, when 1, write 0 to ADDR_OP after the result is captured

Ports:
- CLK  in  1  system clock; all state changes on the rising edge
- RST  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (IDLE only)
- req_a  in  32  operand A
- req_b  in  32  operand B
- req_op  in  32  opcode
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes the result
- resp_data  out  32  captured result
- resp_err  out  1  request rejected (opcode 0); resp_data = 0
- busy  out  1  high in every state except IDLE
- EntradaCalcu  out  32  mailbox write data
- addressCalcu  out  32  mailbox address (write or read)
- writeEnableCalcu  out  1  mailbox write strobe, level WE_ACTIVE = write
- resultadoCalcu  in  32  mailbox read data, combinational for addressCalcu

Behaviour:
- Clock and reset: single clock CLK; RST is asynchronous and active-high.
- Reset values (asserted asynchronously):
  - State IDLE; req_ready = 1; resp_valid = 0; resp_err = 0; resp_data = 0; busy = 0.
  - EntradaCalcu = 0; addressCalcu = 0; writeEnableCalcu = ~WE_ACTIVE; wait counter = 0.
- Reset mid-operation aborts immediately and leaves no write strobe asserted. Partially written mailbox contents are not repaired.
- All bus outputs (EntradaCalcu, addressCalcu, writeEnableCalcu) are registered. The value shown for each state is driven during that state's cycle.
- FSM states, transitions and bus values:
  - IDLE: bus address 0, data 0, write inactive.
    - On req_valid & req_ready, latch req_a, req_b, req_op.
    - If req_op == 0: go to RESP with resp_err = 1 and resp_data = 0 (no bus traffic).
    - Otherwise go to WR_A.
  - WR_A: addr = ADDR_A, data = A, write active, 1 cycle -> WR_B.
  - WR_B: addr = ADDR_B, data = B, write active, 1 cycle -> WR_OP.
  - WR_OP: addr = ADDR_OP, data = op, write active, 1 cycle -> WAIT (or READ if LATENCY == 0).
  - WAIT: write inactive, addr = ADDR_RES; counter counts 1..LATENCY, then -> READ. Counter width = max(1, clog2(LATENCY+1)); counter is cleared on entry.
  - READ: addr = ADDR_RES, write inactive; resp_data <= resultadoCalcu at the end of the cycle.
    - Next state is CLR_OP if CLEAR_OP, else RESP.
  - CLR_OP: addr = ADDR_OP, data = 0, write active, 1 cycle -> RESP.
  - RESP: write inactive, address 0; resp_valid = 1. Hold resp_data and resp_err stable until resp_valid & resp_ready.
    - On that cycle return to IDLE; resp_valid and resp_err clear on the next edge.
- Latency: accepting edge to resp_valid = 3 + LATENCY + 1 + CLEAR_OP + 1 cycles. With defaults that is 70 cycles.
- Handshakes:
  - req_ready = 1 only in IDLE. req_valid while busy is ignored and not queued.
  - A request may not be accepted in the same cycle a response completes; the block needs one IDLE cycle first.
- Back-pressure: resp_ready low holds RESP indefinitely with no bus activity.
- Data is passed through unmodified; no sign or width conversion.

Decomposition:
- Shared package calc_pkg holds:
  - state encoding typedef (IDLE, WR_A, WR_B, WR_OP, WAIT, READ, CLR_OP, RESP);
  - default mailbox address constants (0/16/20/24);
  - OP_NONE = 0.
- The processor testbench reuses the same constants.
- One natural sub-module: calc_wait_timer, a loadable down-counter with a done pulse that implements the WAIT state.

Test Plan:
- Reset: assert RST mid-WR_B -> next sample shows writeEnableCalcu = ~WE_ACTIVE, address 0, req_ready = 1, resp_valid = 0.
- Basic add (LATENCY = 4, CLEAR_OP = 1):
  - Stimulus: A = 99, B = 10, op = 1; memory model returns 109 at addr 24.
  - Bus trace: writes (16, 99), (20, 10), (0, 1), then 4 wait cycles, read at 24, write (0, 0).
  - Response: resp_valid with resp_data = 109 and resp_err = 0, exactly 10 cycles after acceptance.
- Opcode 0 request: A = 5, B = 7, op = 0 -> no write strobe ever asserted; resp_valid next cycle with resp_err = 1, resp_data = 0.
- Back-pressure: hold resp_ready = 0 for 20 cycles with req_valid = 1 and new data.
  - resp_data stays stable and req_ready stays 0.
  - The second request is accepted only after the handshake plus one IDLE cycle.
- LATENCY = 0, CLEAR_OP = 0, A = 0xFFFFFFFF, B = 1, op = 2, model returns 0 -> READ directly follows WR_OP; resp_data = 0; no write to addr 0 after READ.
- Back-to-back: three requests issued with resp_ready tied 1 -> three correct results in order; every mailbox write lasts exactly one cycle.
